bht_predictor: RTL and testbench
================================

Name: bht_predictor

Overview:
- Parametrised branch history table that succeeds the single-entry 2-state-bit predictor; sits beside the IF/ID stage of the pipeline.
- Holds 2^IDX_W saturating counters of CNT_W bits each.
- Indexing is bimodal (PC only) or gshare (PC XOR global history register).
- Lookup is combinational. Updates come from the resolve stage and take effect on the next clock. A saturating mispredict counter is kept for performance measurement.

Parameters:
PC_W, 32, width of program counter
IDX_W, 4, table index width; table depth = 2^IDX_W
CNT_W, 2, counter width per entry (legal 1..4)
GHR_W, 4, global history length (legal 1..IDX_W)
MODE, 0, 0 = bimodal, 1 = gshare

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  reset: synchronous, active-high
lu_pc  input  PC_W  PC being fetched
lu_pred  output  1  predicted taken (1) / not taken (0)
lu_ghr  output  GHR_W  GHR snapshot used for this lookup; carried down the pipe
upd_valid  input  1  resolved branch present
upd_stall  input  1  pipeline stall; blocks update when high
upd_pc  input  PC_W  PC of the resolved branch
upd_ghr  input  GHR_W  lu_ghr captured when that branch was looked up
upd_taken  input  1  actual outcome
upd_mispred  input  1  prediction was wrong
mispred_cnt  output  16  saturating count of mispredictions
ghr  output  GHR_W  current global history

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset state (rst high at a rising edge):
  - every counter = 2^(CNT_W-1)-1 (weakly not-taken; 2'b01 for CNT_W=2);
  - ghr = 0; mispred_cnt = 0.
  - After reset, lu_pred = 0 for every PC.
  - rst has priority over any simultaneous update. Reset in the middle of a run discards all history.
- Index function:
  - base = pc[IDX_W+1:2], word-aligned; bits [1:0] are ignored.
  - MODE 0: idx = base.
  - MODE 1: idx = base XOR zero-extended GHR.
  - Lookup uses the live ghr. Update uses upd_ghr.
- Lookup:
  - combinational, zero latency;
  - lu_pred = MSB of table[lu_idx];
  - lu_ghr = ghr in MODE 1, 0 in MODE 0.
- Update fires when upd_valid=1 and upd_stall=0:
  - taken: counter = min(cnt+1, 2^CNT_W-1). Not taken: counter = max(cnt-1, 0). No wrap-around in either direction.
  - MODE 1: ghr <= {ghr[GHR_W-2:0], upd_taken}. For GHR_W=1, ghr <= upd_taken. ghr is non-speculative.
  - MODE 0: ghr stays 0.
  - upd_mispred=1: mispred_cnt increments, saturating at 16'hFFFF.
- When upd_valid=0 or upd_stall=1, no table, ghr or counter state changes.
- Same-cycle lookup and update to the same entry: lu_pred reflects the pre-update value. The new value is visible from the next cycle (read-before-write).
- Exactly one entry changes per update. All other entries hold their value.
- CNT_W=1 degenerates to a last-outcome predictor: the counter toggles between 0 and 1.

Test Plan:
1. Reset, MODE 0, defaults:
   - lu_pc=0x100 -> lu_pred=0, mispred_cnt=0.
   - Then update pc=0x100, taken=1 -> next cycle lu_pred=1 (counter 01->10).
2. Saturation:
   - 5 taken updates to pc=0x40 -> counter holds 2'b11.
   - Then one not-taken -> lu_pred still 1 (counter 10).
   - Then a second not-taken -> lu_pred=0.
3. Stall and aliasing:
   - Update pc=0x40 taken with upd_stall=1 -> no change, lu_pred=0.
   - pc=0x80 (same index as 0x40 when IDX_W=4) after unstalled taken updates to 0x40 -> aliased lu_pred=1.
4. Gshare, MODE=1, GHR_W=4:
   - Updates taken,taken,not,taken -> ghr=4'b1101.
   - lu_pc=0x10 then indexes entry 4^13=9.
   - An update with upd_ghr=4'b1101 modifies only entry 9.
5. Read/write collision: lookup and update of the same entry in one cycle -> lu_pred shows the old MSB that cycle and the new MSB the next cycle.
6. Counter and reset:
   - mispred_cnt preset near limit via 65535 mispredict updates -> further mispredicts hold 16'hFFFF.
   - Assert rst mid-stream together with upd_valid=1 -> all counters weakly not-taken, ghr=0, mispred_cnt=0.

Source files
------------

// File: rtl/bht_predictor.sv
// rtl/bht_predictor.sv - Bimodal/gshare branch history table with saturating counters
module bht_predictor #(
   parameter int PC_W  = 32,
   parameter int IDX_W = 4,
   parameter int CNT_W = 2,
   parameter int GHR_W = 4,
   parameter int MODE  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PC_W-1:0]  lu_pc,
   output logic             lu_pred,
   output logic [GHR_W-1:0] lu_ghr,
   input  logic             upd_valid,
   input  logic             upd_stall,
   input  logic [PC_W-1:0]  upd_pc,
   input  logic [GHR_W-1:0] upd_ghr,
   input  logic             upd_taken,
   input  logic             upd_mispred,
   output logic [15:0]      mispred_cnt,
   output logic [GHR_W-1:0] ghr
);

   localparam int               DEPTH    = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_MAX >> 1;

   logic [CNT_W-1:0] cnt_tab [DEPTH];
   logic [GHR_W-1:0] ghr_q;
   logic [15:0]      mcnt_q;
   logic [IDX_W-1:0] lu_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [CNT_W-1:0] upd_cur;
   logic [CNT_W-1:0] upd_nxt;
   logic             upd_fire;
   logic             unused_bits;

   // Lookup hashes with the live history; update uses the history the branch saw at fetch.
   always_comb begin
      if (MODE == 1) begin
         lu_idx  = lu_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
         upd_idx = upd_pc[IDX_W+1:2] ^ IDX_W'(upd_ghr);
      end else begin
         lu_idx  = lu_pc[IDX_W+1:2];
         upd_idx = upd_pc[IDX_W+1:2];
      end
   end

   always_comb begin
      lu_pred = cnt_tab[lu_idx][CNT_W-1];
      lu_ghr  = (MODE == 1) ? ghr_q : '0;
   end

   always_comb begin
      upd_fire = upd_valid & ~upd_stall;
      upd_cur  = cnt_tab[upd_idx];
      upd_nxt  = upd_cur;
      if (upd_taken) begin
         if (upd_cur != CNT_MAX)
            upd_nxt = upd_cur + CNT_W'(1);
      end else begin
         if (upd_cur != '0)
            upd_nxt = upd_cur - CNT_W'(1);
      end
   end

   // Reset outranks a coincident update so a mid-run reset always yields a clean table.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            cnt_tab[i] <= CNT_INIT;
         ghr_q  <= '0;
         mcnt_q <= '0;
      end else if (upd_fire) begin
         cnt_tab[upd_idx] <= upd_nxt;
         if (MODE == 1)
            ghr_q <= GHR_W'({ghr_q, upd_taken});
         if (upd_mispred && (mcnt_q != 16'hFFFF))
            mcnt_q <= mcnt_q + 16'd1;
      end
   end

   assign ghr         = ghr_q;
   assign mispred_cnt = mcnt_q;

   assign unused_bits = ^{lu_pc[PC_W-1:IDX_W+2], lu_pc[1:0],
                          upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0], upd_ghr};

endmodule

// File: tb/tb_bht_predictor.sv
// tb/tb_bht_predictor.sv - Self-checking bench for bht_predictor in bimodal and gshare modes
module tb_bht_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] lu_pc;
   logic        upd_valid;
   logic        upd_stall;
   logic [31:0] upd_pc;
   logic [3:0]  upd_ghr;
   logic        upd_taken;
   logic        upd_mispred;

   logic        lu_pred0, lu_pred1;
   logic [3:0]  lu_ghr0, lu_ghr1;
   logic [15:0] mcnt0, mcnt1;
   logic [3:0]  ghr0, ghr1;

   int checks = 0;
   int errors = 0;

   int tab0 [16];
   int tab1 [16];
   int ghr_m;
   int mcnt_m;

   bht_predictor #(.PC_W(32), .IDX_W(4), .CNT_W(2), .GHR_W(4), .MODE(0)) dut0 (
      .clk(clk), .rst(rst), .lu_pc(lu_pc), .lu_pred(lu_pred0), .lu_ghr(lu_ghr0),
      .upd_valid(upd_valid), .upd_stall(upd_stall), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
      .upd_taken(upd_taken), .upd_mispred(upd_mispred), .mispred_cnt(mcnt0), .ghr(ghr0)
   );

   bht_predictor #(.PC_W(32), .IDX_W(4), .CNT_W(2), .GHR_W(4), .MODE(1)) dut1 (
      .clk(clk), .rst(rst), .lu_pc(lu_pc), .lu_pred(lu_pred1), .lu_ghr(lu_ghr1),
      .upd_valid(upd_valid), .upd_stall(upd_stall), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
      .upd_taken(upd_taken), .upd_mispred(upd_mispred), .mispred_cnt(mcnt1), .ghr(ghr1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int c, input logic t);
      if (t) return (c < 3) ? c + 1 : 3;
      return (c > 0) ? c - 1 : 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         tab0[i] = 1;
         tab1[i] = 1;
      end
      ghr_m  = 0;
      mcnt_m = 0;
   endtask

   task automatic model_step();
      int i0, i1;
      if (rst) begin
         model_reset();
      end else if (upd_valid && !upd_stall) begin
         i0 = (upd_pc >> 2) & 15;
         i1 = i0 ^ int'(upd_ghr);
         tab0[i0] = sat(tab0[i0], upd_taken);
         tab1[i1] = sat(tab1[i1], upd_taken);
         ghr_m = ((ghr_m << 1) | int'(upd_taken)) & 15;
         if (upd_mispred && mcnt_m < 65535) mcnt_m++;
      end
   endtask

   task automatic check_outputs();
      int i0, i1;
      i0 = (lu_pc >> 2) & 15;
      i1 = i0 ^ ghr_m;
      chk("pred_bimodal", 32'(lu_pred0), 32'(tab0[i0] >= 2));
      chk("pred_gshare",  32'(lu_pred1), 32'(tab1[i1] >= 2));
      chk("lu_ghr_bimodal", 32'(lu_ghr0), 32'(0));
      chk("lu_ghr_gshare",  32'(lu_ghr1), 32'(ghr_m));
      chk("ghr_bimodal", 32'(ghr0), 32'(0));
      chk("ghr_gshare",  32'(ghr1), 32'(ghr_m));
      chk("mcnt_bimodal", 32'(mcnt0), 32'(mcnt_m));
      chk("mcnt_gshare",  32'(mcnt1), 32'(mcnt_m));
   endtask

   task automatic cycle(input logic r, input logic v, input logic s, input logic [31:0] upc,
                        input logic [3:0] ughr, input logic t, input logic m,
                        input logic [31:0] lpc, input bit do_chk);
      rst = r; upd_valid = v; upd_stall = s; upd_pc = upc;
      upd_ghr = ughr; upd_taken = t; upd_mispred = m; lu_pc = lpc;
      #4;
      if (do_chk) check_outputs();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic t, input logic m);
      cycle(1'b0, 1'b1, 1'b0, pc, 4'(ghr_m), t, m, pc, 1'b1);
   endtask

   task automatic look(input logic [31:0] pc);
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, pc, 1'b1);
   endtask

   task automatic scan();
      for (int b = 0; b < 16; b++) look(32'(b << 2));
   endtask

   initial begin
      model_reset();
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h100, 1'b0);

      // 1: reset state and first taken update
      look(32'h100);
      chk("reset_pred", 32'(lu_pred0), 32'd0);
      chk("reset_mcnt", 32'(mcnt0), 32'd0);
      scan();
      upd(32'h100, 1'b1, 1'b0);
      look(32'h100);
      chk("first_taken_pred", 32'(lu_pred0), 32'd1);

      // 2: saturation and decay
      for (int k = 0; k < 5; k++) upd(32'h40, 1'b1, 1'b0);
      upd(32'h40, 1'b0, 1'b1);
      look(32'h40);
      chk("one_not_taken", 32'(lu_pred0), 32'd1);
      upd(32'h40, 1'b0, 1'b1);
      look(32'h40);
      chk("two_not_taken", 32'(lu_pred0), 32'd0);

      // 3: stall blocks update, aliasing
      cycle(1'b0, 1'b1, 1'b1, 32'h40, 4'(ghr_m), 1'b1, 1'b1, 32'h40, 1'b1);
      look(32'h40);
      chk("stall_no_change", 32'(lu_pred0), 32'd0);
      upd(32'h40, 1'b1, 1'b0);
      upd(32'h40, 1'b1, 1'b0);
      look(32'h80);
      chk("alias_pred", 32'(lu_pred0), 32'd1);

      // 4: gshare history and single-entry update
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      upd(32'h200, 1'b1, 1'b0);
      upd(32'h200, 1'b1, 1'b0);
      upd(32'h200, 1'b0, 1'b0);
      upd(32'h200, 1'b1, 1'b0);
      look(32'h10);
      chk("ghr_1101", 32'(ghr1), 32'hD);
      cycle(1'b0, 1'b1, 1'b0, 32'h10, 4'b1101, 1'b1, 1'b0, 32'h10, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 32'h10, 4'b1101, 1'b1, 1'b0, 32'h10, 1'b1);
      scan();

      // 5: read-before-write collision on one entry
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      upd(32'h24, 1'b1, 1'b0);
      chk("collision_new", 32'(lu_pred0), 32'd1);

      // random traffic against the model
      for (int k = 0; k < 400; k++) begin
         logic [31:0] pc_u, pc_l;
         logic [3:0]  ug;
         pc_u = $urandom;
         pc_l = ($urandom_range(0, 1) == 0) ? pc_u : $urandom;
         ug   = ($urandom_range(0, 3) != 0) ? 4'(ghr_m) : 4'($urandom_range(0, 15));
         cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) == 0), pc_u, ug, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), pc_l, 1'b1);
      end

      // 6: mispredict counter saturation, then reset with concurrent update
      for (int k = 0; k < 65535; k++)
         cycle(1'b0, 1'b1, 1'b0, 32'($urandom), 4'(ghr_m), 1'($urandom_range(0, 1)),
               1'b1, 32'h0, 1'b0);
      look(32'h0);
      chk("mcnt_sat", 32'(mcnt0), 32'hFFFF);
      upd(32'h44, 1'b1, 1'b1);
      upd(32'h48, 1'b0, 1'b1);
      chk("mcnt_hold", 32'(mcnt1), 32'hFFFF);
      cycle(1'b1, 1'b1, 1'b0, 32'h40, 4'(ghr_m), 1'b1, 1'b1, 32'h40, 1'b1);
      look(32'h40);
      chk("rst_mcnt", 32'(mcnt0), 32'd0);
      chk("rst_ghr", 32'(ghr1), 32'd0);
      chk("rst_pred", 32'(lu_pred0), 32'd0);
      scan();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
